// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared parameters and helpers for the round-robin FIFO arbiter.
package fifo_rr_arbiter_pkg;

    localparam int DEF_N_IN      = 4;
    localparam int DEF_DATA_SIZE = 6;
    localparam int DEF_DEST_BITS = 2;

    // Ceiling log2 for elaboration-time widths (returns 0 for values <= 1).
    function automatic int clog2_int(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of destination FIFOs addressed by a destination field.
    function automatic int n_out_of(input int dest_bits);
        return 1 << dest_bits;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_select.sv
// Combinational round-robin picker: first eligible index at or after the
// pointer, wrapping modulo N_IN (N_IN is a power of two, so the index
// arithmetic wraps by truncation).
module fifo_rr_arbiter_rr_select
    import fifo_rr_arbiter_pkg::*;
#(
    parameter  int N_IN  = DEF_N_IN,
    localparam int PTR_W = clog2_int(N_IN)
) (
    input  logic [N_IN-1:0]  i_eligible,
    input  logic [PTR_W-1:0] i_rr_ptr,
    output logic [N_IN-1:0]  o_grant,
    output logic [PTR_W-1:0] o_grant_idx,
    output logic             o_any_grant
);

    // Scan from the pointer upward and take the first eligible index.
    always_comb begin : pick
        logic [PTR_W-1:0] w_idx;
        logic             w_found;
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_idx = i_rr_ptr + PTR_W'(k);
            if (!w_found && i_eligible[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
        o_any_grant = w_found;
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin consumer of N_IN source FIFOs: grant/pop in stage A, capture
// the popped word and push it to the destination FIFO named by its top
// DEST_BITS in stage B. Grants stall while any destination is almost full.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter  int N_IN      = DEF_N_IN,
    parameter  int DATA_SIZE = DEF_DATA_SIZE,
    parameter  int DEST_BITS = DEF_DEST_BITS,
    localparam int N_OUT     = n_out_of(DEST_BITS),
    localparam int PTR_W     = clog2_int(N_IN)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [N_IN-1:0]           i_src_empty,
    input  logic [N_IN*DATA_SIZE-1:0] i_src_data,
    input  logic [N_OUT-1:0]          i_dst_almost_full,
    input  logic [N_OUT-1:0]          i_dst_full,
    output logic [N_IN-1:0]           o_pop,
    output logic [N_OUT-1:0]          o_push,
    output logic [DATA_SIZE-1:0]      o_data_out,
    output logic                      o_error,
    output logic                      o_idle
);

    logic [PTR_W-1:0]     r_rr_ptr;
    logic [N_IN-1:0]      r_pop;
    logic [PTR_W-1:0]     r_pop_idx;
    logic                 r_cap_pend;
    logic [PTR_W-1:0]     r_cap_idx;
    logic [N_OUT-1:0]     r_push;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_error;

    logic [N_IN-1:0]      w_eligible;
    logic [N_IN-1:0]      w_grant;
    logic [PTR_W-1:0]     w_grant_idx;
    logic                 w_any_grant;
    logic                 w_grant_en;
    logic [DATA_SIZE-1:0] w_cap_word;
    logic [DEST_BITS-1:0] w_cap_dest;
    logic [N_OUT-1:0]     w_dest_onehot;

    // The source empty flag lags a pop by one cycle, so the input popped in
    // the current cycle (r_pop) sits out the next grant.
    assign w_eligible = ~i_src_empty & ~r_pop;
    assign w_grant_en = w_any_grant && (i_dst_almost_full == '0);

    fifo_rr_arbiter_rr_select #(
        .N_IN (N_IN)
    ) u_rr_select (
        .i_eligible  (w_eligible),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    // Stage A: register the grant as the pop strobe and advance the pointer
    // past the granted input; the pointer holds when nothing is granted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pop     <= '0;
            r_pop_idx <= '0;
            r_rr_ptr  <= '0;
        end else begin
            if (w_grant_en) begin
                r_pop     <= w_grant;
                r_pop_idx <= w_grant_idx;
                r_rr_ptr  <= w_grant_idx + PTR_W'(1);
            end else begin
                r_pop     <= '0;
            end
        end
    end

    // Track which source's word appears on the data bus in the next cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cap_pend <= 1'b0;
            r_cap_idx  <= '0;
        end else begin
            r_cap_pend <= |r_pop;
            r_cap_idx  <= r_pop_idx;
        end
    end

    assign w_cap_word = i_src_data[int'(r_cap_idx)*DATA_SIZE +: DATA_SIZE];
    assign w_cap_dest = w_cap_word[DATA_SIZE-1 -: DEST_BITS];

    // Decode the destination field into a one-hot push strobe.
    always_comb begin
        w_dest_onehot             = '0;
        w_dest_onehot[w_cap_dest] = 1'b1;
    end

    // Stage B: push the captured word, or drop it and flag an error when
    // the destination is already full. data_out only moves on a real push.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_push     <= '0;
            r_data_out <= '0;
            r_error    <= 1'b0;
        end else begin
            r_push  <= '0;
            r_error <= 1'b0;
            if (r_cap_pend) begin
                if (i_dst_full[w_cap_dest]) begin
                    r_error <= 1'b1;
                end else begin
                    r_push     <= w_dest_onehot;
                    r_data_out <= w_cap_word;
                end
            end
        end
    end

    assign o_pop      = r_pop;
    assign o_push     = r_push;
    assign o_data_out = r_data_out;
    assign o_error    = r_error;
    assign o_idle     = (r_pop == '0) && !r_cap_pend && (r_push == '0);

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Downstream consumer of a bank of N_IN main-queue FIFOs.
- Each cycle it picks one non-empty source FIFO by round-robin and pops it.
- It captures the word the FIFO presents one cycle later and pushes that word into one of N_OUT destination FIFOs. The destination is selected by the word's top DEST_BITS.
- Popping is throttled by destination almost-full backpressure, which keeps the FIFO stage behind it from overflowing.

Parameters:
- N_IN, 4, number of source FIFOs (power of 2, 2..8)
- DATA_SIZE, 6, word width of every FIFO
- DEST_BITS, 2, destination field width (word bits [DATA_SIZE-1 -: DEST_BITS]); N_OUT = 2**DEST_BITS

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- src_empty  in  N_IN  empty flag of each source FIFO
- src_data  in  N_IN*DATA_SIZE  popped-data bus of each FIFO; slice i = FIFO i
- dst_almost_full  in  N_OUT  almost-full flag of each destination FIFO
- dst_full  in  N_OUT  full flag of each destination FIFO
- pop  out  N_IN  one-hot read strobe to source FIFOs (registered)
- push  out  N_OUT  one-hot write strobe to destination FIFOs (registered)
- data_out  out  DATA_SIZE  word accompanying push
- error  out  1  one-cycle pulse: push attempted into a full destination
- idle  out  1  high when no pop or capture is in flight

Behaviour:
- Reset (async assert, released synchronously to clk): pop=0, push=0, data_out=0, error=0, idle=1, rr pointer=0, all in-flight state cleared. Reset mid-operation drops any pending capture; no push follows.
- Source timing contract: pop[i] high in cycle k → src_data slice i is valid in cycle k+1.
- Pipeline: two stages, one word per cycle sustained.
  - Stage A grant: registered pop.
  - Stage B capture: registers src_data[granted], drives push and data_out in cycle k+2.
- Grant rule in cycle k (combinational, registered into pop at edge):
  - An input is eligible iff src_empty[i]==0 and it was not granted in the previous cycle.
  - The cooldown exists because the empty flag lags a pop by one cycle.
  - Grant is blocked entirely if any dst_almost_full bit is 1.
  - Otherwise grant the first eligible index at or after rr_ptr, modulo N_IN; then rr_ptr = granted+1 (wraps N_IN-1→0).
  - No eligible input: pop=0 and rr_ptr holds.
- Capture: cycle after pop[i], word = src_data slice i, dest = word[DATA_SIZE-1 -: DEST_BITS].
  - Next edge: push = one-hot(dest), data_out = word.
  - If dst_full[dest] is 1 at capture, push=0, error=1 for one cycle, and the word is dropped.
  - push is 0 in cycles without a capture; data_out holds its last value.
- Backpressure arriving while a pop is in flight does not cancel it. The in-flight word still pushes (almost_full margin ≥2 is a system requirement).
- idle = (pop==0) && (no capture pending) && (push==0).
- All arithmetic unsigned; rr_ptr width clog2(N_IN).

Decomposition:
- Shared package: DEST_BITS, N_OUT derivation, clog2 helper, default DATA_SIZE.
- One sub-module rr_select: combinational N_IN-wide round-robin priority picker.
  - Inputs: eligible mask, rr_ptr.
  - Outputs: one-hot grant, grant index, any_grant.
- Top holds the pointer, cooldown mask, capture register and error logic.

Test Plan:
1. Reset then sources all empty for 10 cycles → pop=0, push=0, idle=1, error=0 throughout.
2. Only FIFO0 non-empty holding words 6'b01_0011 and 6'b11_0101 → pop[0] in cycles 1 and 3, never in consecutive cycles. Two cycles after each pop, push=4'b0010 with data_out=6'h13, then push=4'b1000 with data_out=6'h35.
3. All four sources non-empty with 3 words each → pop sequence 0,1,2,3,0,1,2,3,0,1,2,3, one pop per cycle, 12 pushes in matching order.
4. dst_almost_full[2] raised during a stream → pop goes 0 on the next edge. The in-flight word (one pop already issued) still pushes. Lowering the flag resumes grants at the saved rr_ptr.
5. Captured word targets dest 1 while dst_full[1]=1 → push stays 0000, error pulses 1 cycle, and the next word proceeds normally.
6. Assert reset while pop[3] is high and a capture is pending → outputs 0 immediately (async), no push after release, and the first grant after release goes to the lowest eligible index from 0.
